// File: rtl/bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer
//
// Down-counting MM:SS irrigation-duration timer. A BCD duration is loaded,
// then decremented by one second every PRESCALE ticks while running. A
// borrow chain runs across the four digits. Reaching 00:00 pulses done for
// one cycle, which closes the valve.
//
// Ports
//   clk           system clock
//   clear         synchronous active-high reset, overrides everything
//   tick          single-cycle enable from the 1 Hz generator
//   load          single-cycle request to load the *_in digits
//   min_tens_in   BCD minutes tens  (0..MIN_TENS_MAX)
//   min_units_in  BCD minutes units (0..9)
//   sec_tens_in   BCD seconds tens  (0..5)
//   sec_units_in  BCD seconds units (0..9)
//   start         single-cycle begin/resume request
//   stop          single-cycle pause request
//   min_tens .. sec_units  current count (registered)
//   running       high while counting down
//   done          one-cycle pulse on reaching 00:00
//   load_err      one-cycle pulse when a load is rejected
// ---------------------------------------------------------------------------
module bcd_countdown_timer #(
    parameter int PRESCALE     = 1,
    parameter int MIN_TENS_MAX = 9
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] min_tens_in,
    input  logic [3:0] min_units_in,
    input  logic [3:0] sec_tens_in,
    input  logic [3:0] sec_units_in,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       running,
    output logic       done,
    output logic       load_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] PRESCALE_LAST = 4'(PRESCALE - 1);
    localparam logic [3:0] MIN_TENS_LIM  = 4'(MIN_TENS_MAX);

    state_t      state_q,    state_d;
    logic [15:0] count_q,    count_d;    // {min_tens, min_units, sec_tens, sec_units}
    logic [3:0]  presc_q,    presc_d;
    logic        running_q,  running_d;
    logic        done_q,     done_d;
    logic        load_err_q, load_err_d;

    logic [15:0] load_val_s;
    logic        load_ok_s;
    logic        count_zero_s;

    // Decrement an MM:SS BCD count by one second; callers guarantee c != 0.
    function automatic logic [15:0] bcd_dec(input logic [15:0] c);
        logic [3:0] mt, mu, st, su;
        logic       b;
        mt = c[15:12];
        mu = c[11:8];
        st = c[7:4];
        su = c[3:0];
        if (su == 4'd0) begin
            su = 4'd9;
            b  = 1'b1;
        end else begin
            su = su - 4'd1;
            b  = 1'b0;
        end
        if (b) begin
            if (st == 4'd0) begin
                st = 4'd5;
            end else begin
                st = st - 4'd1;
                b  = 1'b0;
            end
        end
        if (b) begin
            if (mu == 4'd0) begin
                mu = 4'd9;
            end else begin
                mu = mu - 4'd1;
                b  = 1'b0;
            end
        end
        if (b && (mt != 4'd0)) begin
            mt = mt - 4'd1;
        end
        return {mt, mu, st, su};
    endfunction

    // A load is legal when every digit is BCD and both tens digits are in range.
    function automatic logic bcd_load_ok(input logic [15:0] v);
        return (v[15:12] <= 4'd9) && (v[15:12] <= MIN_TENS_LIM) &&
               (v[11:8]  <= 4'd9) &&
               (v[7:4]   <= 4'd5) &&
               (v[3:0]   <= 4'd9);
    endfunction

    assign load_val_s   = {min_tens_in, min_units_in, sec_tens_in, sec_units_in};
    assign load_ok_s    = bcd_load_ok(load_val_s);
    assign count_zero_s = (count_q == 16'h0000);

    // Next-state logic: load > stop > start > tick; clear is applied in the register.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        presc_d    = presc_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;

        // A load while running is simply ignored and lets stop/tick proceed.
        if (load && (state_q != ST_RUN)) begin
            if (load_ok_s) begin
                count_d = load_val_s;
                state_d = ST_IDLE;
                presc_d = 4'd0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (stop && (state_q == ST_RUN)) begin
            state_d = ST_PAUSED;
        end else if (start && ((state_q == ST_IDLE) || (state_q == ST_PAUSED)) && !count_zero_s) begin
            state_d = ST_RUN;
            presc_d = 4'd0;
        end else if (tick && (state_q == ST_RUN)) begin
            if (presc_q == PRESCALE_LAST) begin
                presc_d = 4'd0;
                count_d = bcd_dec(count_q);
                if (count_q == 16'h0001) begin
                    state_d = ST_EXPIRED;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end else begin
                presc_d = presc_q + 4'd1;
            end
        end else begin
            state_d = state_q;
        end

        case (state_d)
            ST_RUN:  running_d = 1'b1;
            default: running_d = 1'b0;
        endcase
    end

    // State, count and registered outputs with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= ST_IDLE;
            count_q    <= 16'h0000;
            presc_q    <= 4'd0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
            running_q  <= running_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign min_tens  = count_q[15:12];
    assign min_units = count_q[11:8];
    assign sec_tens  = count_q[7:4];
    assign sec_units = count_q[3:0];
    assign running   = running_q;
    assign done      = done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_bcd_countdown_timer
//
// Directed bench with hand-computed expectations. Two instances share the
// stimulus: u_p1 (PRESCALE=1) and u_p4 (PRESCALE=4).
// ---------------------------------------------------------------------------
module tb_bcd_countdown_timer;

    logic       clk;
    logic       clear;
    logic       tick;
    logic       load;
    logic [3:0] min_tens_in;
    logic [3:0] min_units_in;
    logic [3:0] sec_tens_in;
    logic [3:0] sec_units_in;
    logic       start;
    logic       stop;

    logic [3:0] p1_mt, p1_mu, p1_st, p1_su;
    logic       p1_running, p1_done, p1_load_err;
    logic [3:0] p4_mt, p4_mu, p4_st, p4_su;
    logic       p4_running, p4_done, p4_load_err;

    int n_vec;
    int n_err;

    bcd_countdown_timer #(.PRESCALE(1), .MIN_TENS_MAX(9)) u_p1 (
        .clk          (clk),
        .clear        (clear),
        .tick         (tick),
        .load         (load),
        .min_tens_in  (min_tens_in),
        .min_units_in (min_units_in),
        .sec_tens_in  (sec_tens_in),
        .sec_units_in (sec_units_in),
        .start        (start),
        .stop         (stop),
        .min_tens     (p1_mt),
        .min_units    (p1_mu),
        .sec_tens     (p1_st),
        .sec_units    (p1_su),
        .running      (p1_running),
        .done         (p1_done),
        .load_err     (p1_load_err)
    );

    bcd_countdown_timer #(.PRESCALE(4), .MIN_TENS_MAX(9)) u_p4 (
        .clk          (clk),
        .clear        (clear),
        .tick         (tick),
        .load         (load),
        .min_tens_in  (min_tens_in),
        .min_units_in (min_units_in),
        .sec_tens_in  (sec_tens_in),
        .sec_units_in (sec_units_in),
        .start        (start),
        .stop         (stop),
        .min_tens     (p4_mt),
        .min_units    (p4_mu),
        .sec_tens     (p4_st),
        .sec_units    (p4_su),
        .running      (p4_running),
        .done         (p4_done),
        .load_err     (p4_load_err)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge with the currently driven inputs, then drop the pulses.
    task automatic cycle();
        @(posedge clk);
        #1;
        clear = 1'b0;
        tick  = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic set_digits(input logic [15:0] v);
        min_tens_in  = v[15:12];
        min_units_in = v[11:8];
        sec_tens_in  = v[7:4];
        sec_units_in = v[3:0];
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle();
    endtask

    task automatic do_load(input logic [15:0] v);
        set_digits(v);
        load = 1'b1;
        cycle();
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cycle();
    endtask

    function automatic logic [15:0] p1_cnt();
        return {p1_mt, p1_mu, p1_st, p1_su};
    endfunction

    function automatic logic [15:0] p4_cnt();
        return {p4_mt, p4_mu, p4_st, p4_su};
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        clear = 1'b1;
        tick  = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        set_digits(16'h0000);
        #2;

        // Reset state.
        cycle();
        check_val("rst_cnt",      p1_cnt(), 16'h0000);
        check_val("rst_running",  {15'd0, p1_running},  16'd0);
        check_val("rst_done",     {15'd0, p1_done},     16'd0);
        check_val("rst_load_err", {15'd0, p1_load_err}, 16'd0);
        check_val("rst_p4_cnt",   p4_cnt(), 16'h0000);
        do_start();
        check_val("rst_start_ign", {15'd0, p1_running}, 16'd0);

        // Basic countdown 00:03 with PRESCALE=1.
        do_clear();
        do_load(16'h0003);
        check_val("basic_load", p1_cnt(), 16'h0003);
        do_start();
        check_val("basic_run", {15'd0, p1_running}, 16'd1);
        do_tick();
        check_val("basic_t1", p1_cnt(), 16'h0002);
        check_val("basic_t1_done", {15'd0, p1_done}, 16'd0);
        do_tick();
        check_val("basic_t2", p1_cnt(), 16'h0001);
        do_tick();
        check_val("basic_t3", p1_cnt(), 16'h0000);
        check_val("basic_t3_done", {15'd0, p1_done}, 16'd1);
        check_val("basic_t3_run",  {15'd0, p1_running}, 16'd0);
        cycle();
        check_val("basic_done_1cyc", {15'd0, p1_done}, 16'd0);
        do_tick();
        check_val("basic_no_wrap", p1_cnt(), 16'h0000);
        check_val("basic_no_wrap_done", {15'd0, p1_done}, 16'd0);
        do_start();
        check_val("expired_start_ign", {15'd0, p1_running}, 16'd0);

        // Borrow chain.
        do_clear();
        do_load(16'h1000);
        do_start();
        do_tick();
        check_val("borrow_1000", p1_cnt(), 16'h0959);
        do_clear();
        do_load(16'h0100);
        do_start();
        do_tick();
        check_val("borrow_0100", p1_cnt(), 16'h0059);
        do_clear();
        do_load(16'h2000);
        do_start();
        do_tick();
        check_val("borrow_2000", p1_cnt(), 16'h1959);

        // Invalid loads leave count and IDLE state intact.
        do_clear();
        do_load(16'h0500);
        check_val("inv_base", p1_cnt(), 16'h0500);
        do_load(16'h0760);
        check_val("inv_sectens_err", {15'd0, p1_load_err}, 16'd1);
        check_val("inv_sectens_cnt", p1_cnt(), 16'h0500);
        cycle();
        check_val("inv_err_1cyc", {15'd0, p1_load_err}, 16'd0);
        do_load(16'h0A00);
        check_val("inv_minunits_err", {15'd0, p1_load_err}, 16'd1);
        check_val("inv_minunits_cnt", p1_cnt(), 16'h0500);
        do_load(16'hA000);
        check_val("inv_mintens_err", {15'd0, p1_load_err}, 16'd1);
        check_val("inv_state_idle", {15'd0, p1_running}, 16'd0);
        do_start();
        check_val("inv_then_start", {15'd0, p1_running}, 16'd1);

        // Pause/resume with PRESCALE=4 (p1 also follows every tick).
        do_clear();
        do_load(16'h0010);
        do_start();
        for (int i = 0; i < 3; i++) do_tick();
        check_val("p4_pre_stop", p4_cnt(), 16'h0010);
        check_val("p1_pre_stop", p1_cnt(), 16'h0007);
        stop = 1'b1;
        cycle();
        check_val("p4_paused_run", {15'd0, p4_running}, 16'd0);
        for (int i = 0; i < 5; i++) do_tick();
        check_val("p4_paused_hold", p4_cnt(), 16'h0010);
        check_val("p1_paused_hold", p1_cnt(), 16'h0007);
        do_start();
        check_val("p4_resume_run", {15'd0, p4_running}, 16'd1);
        for (int i = 0; i < 3; i++) do_tick();
        check_val("p4_resume_t3", p4_cnt(), 16'h0010);
        do_tick();
        check_val("p4_resume_t4", p4_cnt(), 16'h0009);
        check_val("p1_resume_t4", p1_cnt(), 16'h0003);

        // load + start together loads only.
        do_clear();
        set_digits(16'h0005);
        load  = 1'b1;
        start = 1'b1;
        cycle();
        check_val("ldst_cnt", p1_cnt(), 16'h0005);
        check_val("ldst_idle", {15'd0, p1_running}, 16'd0);

        // stop + decrementing tick: no decrement, PAUSED.
        do_start();
        stop = 1'b1;
        tick = 1'b1;
        cycle();
        check_val("stoptick_cnt", p1_cnt(), 16'h0005);
        check_val("stoptick_run", {15'd0, p1_running}, 16'd0);
        do_start();
        do_tick();
        check_val("stoptick_resume", p1_cnt(), 16'h0004);

        // load during RUN is ignored without error.
        do_load(16'h0900);
        check_val("ldrun_cnt", p1_cnt(), 16'h0004);
        check_val("ldrun_err", {15'd0, p1_load_err}, 16'd0);
        check_val("ldrun_run", {15'd0, p1_running}, 16'd1);

        // clear mid-RUN at 03:27.
        do_clear();
        do_load(16'h0327);
        do_start();
        check_val("clr_pre_run", {15'd0, p1_running}, 16'd1);
        clear = 1'b1;
        tick  = 1'b1;
        load  = 1'b1;
        cycle();
        check_val("clr_cnt", p1_cnt(), 16'h0000);
        check_val("clr_run", {15'd0, p1_running}, 16'd0);
        check_val("clr_p4_cnt", p4_cnt(), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
